// File: rtl/datapath_pair_alu_stage_if.sv
// Paired operand bus into the ALU stage and result bus out of it.
// master drives operands and out_ready; slave is the ALU stage itself.
interface datapath_pair_alu_stage_if #(
    parameter int DWID   = 24,
    parameter int CH_NUM = 8
) ();
    // Valid/ready: a beat transfers on a cycle where valid && ready are both high;
    // the sender keeps valid, data and op stable until that transfer happens.
    logic [1:0]                         op;
    logic                               in_valid;
    logic                               in_ready;
    logic [CH_NUM-1:0][DWID-1:0]        in0_data;
    logic [CH_NUM-1:0][DWID-1:0]        in1_data;
    logic                               out_valid;
    logic                               out_ready;
    logic [CH_NUM-1:0][DWID-1:0]        out_data;
    logic [CH_NUM-1:0]                  sat_flag;

    modport master (
        output op, in_valid, in0_data, in1_data, out_ready,
        input  in_ready, out_valid, out_data, sat_flag
    );

    modport slave (
        input  op, in_valid, in0_data, in1_data, out_ready,
        output in_ready, out_valid, out_data, sat_flag
    );
endinterface

// File: rtl/datapath_pair_alu_stage.sv
// Per-channel saturating ALU feeding a 2-entry elastic buffer; in_ready depends
// only on registered occupancy, so no ready path crosses the stage.
module datapath_pair_alu_stage #(
    parameter int DWID   = 24,
    parameter int CH_NUM = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    datapath_pair_alu_stage_if.slave bus,
    output logic [1:0]           dbg_state_o
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef logic [CH_NUM-1:0][DWID-1:0] beat_t;

    localparam logic [DWID-1:0] MAX_POS = {1'b0, {(DWID-1){1'b1}}};
    localparam logic [DWID-1:0] MIN_NEG = {1'b1, {(DWID-1){1'b0}}};

    state_e            state_q, state_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    beat_t             data_q [2];
    logic [CH_NUM-1:0] sat_q  [2];

    beat_t             alu_res;
    logic [CH_NUM-1:0] alu_sat;
    logic              accept;
    logic              retire;

    assign bus.in_ready  = (state_q != ST_FULL);
    assign bus.out_valid = (state_q != ST_EMPTY);
    assign bus.out_data  = data_q[rd_ptr_q];
    assign bus.sat_flag  = sat_q[rd_ptr_q];
    assign dbg_state_o   = state_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign retire = bus.out_valid && bus.out_ready;

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [DWID-1:0] a, b, res_c;
        logic [DWID:0]   add_w, sub_w, arith_w;
        logic            ovf, sat_c;

        assign a       = bus.in0_data[i];
        assign b       = bus.in1_data[i];
        assign add_w   = {a[DWID-1], a} + {b[DWID-1], b};
        assign sub_w   = {a[DWID-1], a} - {b[DWID-1], b};
        assign arith_w = (bus.op == 2'b01) ? add_w : sub_w;
        // Sign bit and extension bit disagree only when the true result left the DWID range.
        assign ovf     = arith_w[DWID] ^ arith_w[DWID-1];

        always_comb begin
            res_c = a;
            sat_c = 1'b0;
            case (bus.op)
                2'b00: res_c = a;
                2'b11: res_c = ($signed(a) >= $signed(b)) ? a : b;
                default: begin
                    if (ovf) begin
                        res_c = arith_w[DWID] ? MIN_NEG : MAX_POS;
                        sat_c = 1'b1;
                    end else begin
                        res_c = arith_w[DWID-1:0];
                    end
                end
            endcase
        end

        assign alu_res[i] = res_c;
        assign alu_sat[i] = sat_c;
    end

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) wr_ptr_d = ~wr_ptr_q;
        if (retire) rd_ptr_d = ~rd_ptr_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_ONE;
            ST_ONE: begin
                if (accept && !retire)      state_d = ST_FULL;
                else if (!accept && retire) state_d = ST_EMPTY;
            end
            ST_FULL:  if (retire) state_d = ST_ONE;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                data_q[k] <= '0;
                sat_q[k]  <= '0;
            end
        end else if (accept) begin
            data_q[wr_ptr_q] <= alu_res;
            sat_q[wr_ptr_q]  <= alu_sat;
        end
    end
endmodule

// File: tb/tb_datapath_pair_alu_stage.sv
// Directed and random stimulus against a queue-based reference of the ALU stage.
module tb_datapath_pair_alu_stage;
    localparam int DWID   = 24;
    localparam int CH_NUM = 8;
    localparam int BW     = DWID * CH_NUM;
    localparam int EW     = BW + CH_NUM;

    logic clk = 1'b0;
    logic rst;
    logic [1:0] dbg_state;
    always #5 clk = ~clk;

    datapath_pair_alu_stage_if #(.DWID(DWID), .CH_NUM(CH_NUM)) bus ();

    datapath_pair_alu_stage #(.DWID(DWID), .CH_NUM(CH_NUM)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int             n_tests = 0;
    int             n_fail  = 0;
    longint         cyc     = 0;
    bit             chk_en  = 1'b0;
    logic [EW-1:0]  exp_q[$];
    longint         acc_log[$];

    function automatic logic [EW-1:0] model(input logic [1:0] op,
                                            input logic [BW-1:0] a,
                                            input logic [BW-1:0] b);
        logic [BW-1:0]     d;
        logic [CH_NUM-1:0] s;
        longint            x, y, r, hi, lo;
        d  = '0;
        s  = '0;
        hi = (longint'(1) << (DWID-1)) - 1;
        lo = -(longint'(1) << (DWID-1));
        for (int i = 0; i < CH_NUM; i++) begin
            x = longint'($signed(a[i*DWID +: DWID]));
            y = longint'($signed(b[i*DWID +: DWID]));
            case (op)
                2'd0:    r = x;
                2'd1:    r = x + y;
                2'd2:    r = x - y;
                default: r = (x >= y) ? x : y;
            endcase
            if (r > hi) begin
                r = hi;
                s[i] = 1'b1;
            end else if (r < lo) begin
                r = lo;
                s[i] = 1'b1;
            end
            d[i*DWID +: DWID] = r[DWID-1:0];
        end
        return {s, d};
    endfunction

    task automatic check(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Model update at the active edge: retire pops the head, accept pushes the new result.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            cyc++;
            if (bus.out_valid && bus.out_ready && exp_q.size() != 0)
                void'(exp_q.pop_front());
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.op, bus.in0_data, bus.in1_data));
                acc_log.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check_bit("in_ready", bus.in_ready, exp_q.size() < 2);
            check_bit("out_valid", bus.out_valid, exp_q.size() != 0);
            check("state", BW'(dbg_state), BW'(exp_q.size()));
            if (exp_q.size() != 0) begin
                check("out_data", bus.out_data, exp_q[0][BW-1:0]);
                check("sat_flag", BW'(bus.sat_flag), BW'(exp_q[0][EW-1:BW]));
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [BW-1:0] a, input logic [BW-1:0] b);
        bit ok;
        int n;
        n = 0;
        bus.op       = op;
        bus.in0_data = a;
        bus.in1_data = b;
        bus.in_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk);
            n++;
        end while (!ok && n < 60);
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready low for %0d cycles, expected 1", n);
        end
        #1;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [BW-1:0] rand_vec();
        logic [BW-1:0] v;
        for (int k = 0; k < BW/32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic [BW-1:0] va, vb, vc, vd, ve, vz;
    bit            done;
    int            s0, s1;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 2'd0;
        bus.in0_data  = '0;
        bus.in1_data  = '0;
        bus.out_ready = 1'b0;
        #12;
        check_bit("rst_in_ready", bus.in_ready, 1'b1);
        check_bit("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, '0);
        check("rst_sat", BW'(bus.sat_flag), '0);
        @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        @(posedge clk);
        #1;

        // Pass: channel i = i, Z1 all ones.
        for (int i = 0; i < CH_NUM; i++) va[i*DWID +: DWID] = DWID'(i);
        vb = {CH_NUM{24'hFFFFFF}};
        bus.out_ready = 1'b1;
        send(2'd0, va, vb);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_bit("pass_valid", bus.out_valid, 1'b1);
        check("pass_data", bus.out_data,
              {24'h7, 24'h6, 24'h5, 24'h4, 24'h3, 24'h2, 24'h1, 24'h0});
        check("pass_sat", BW'(bus.sat_flag), '0);
        idle(2);

        // Saturating add.
        va = {120'h0, 24'h000005, 24'h800000, 24'h7FFFFF};
        vb = {120'h0, 24'hFFFFFE, 24'hFFFFFF, 24'h000001};
        check("model_add", model(2'd1, va, vb)[BW-1:0], {120'h0, 24'h000003, 24'h800000, 24'h7FFFFF});
        send(2'd1, va, vb);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("add_data", bus.out_data, {120'h0, 24'h000003, 24'h800000, 24'h7FFFFF});
        check("add_sat", BW'(bus.sat_flag), BW'(8'b0000_0011));
        idle(2);

        // Saturating subtract, then signed max with an equal pair.
        va = {168'h0, 24'h800000};
        vb = {168'h0, 24'h000001};
        send(2'd2, va, vb);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("sub_data", bus.out_data, {168'h0, 24'h800000});
        check("sub_sat", BW'(bus.sat_flag), BW'(8'b0000_0001));
        idle(2);
        va = {144'h0, 24'h000010, 24'hFFFFFF};
        vb = {144'h0, 24'h000010, 24'h000001};
        check("model_max", model(2'd3, va, vb)[BW-1:0], {144'h0, 24'h000010, 24'h000001});
        send(2'd3, va, vb);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("max_data", bus.out_data, {144'h0, 24'h000010, 24'h000001});
        check("max_sat", BW'(bus.sat_flag), '0);
        idle(2);

        // Backpressure: only two beats fit while out_ready is low.
        va = {CH_NUM{24'h000011}};
        vb = {CH_NUM{24'h000022}};
        vc = {CH_NUM{24'h000033}};
        vd = {CH_NUM{24'h000044}};
        vz = '0;
        bus.out_ready = 1'b0;
        s0 = acc_log.size();
        send(2'd0, va, vz);
        send(2'd0, vb, vz);
        bus.op       = 2'd0;
        bus.in0_data = vc;
        bus.in1_data = vz;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_bit("bp_in_ready", bus.in_ready, 1'b0);
            check("bp_hold_a", bus.out_data, {CH_NUM{24'h000011}});
        end
        check("bp_accepts", BW'(acc_log.size() - s0), BW'(2));
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(2'd0, vc, vz);
        send(2'd0, vd, vz);
        idle(6);
        check("bp_drained", BW'(exp_q.size()), '0);
        check("bp_total", BW'(acc_log.size() - s0), BW'(4));

        // Random streaming with random gaps and out_ready toggling.
        done = 1'b0;
        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
                    send(2'($urandom_range(0, 3)), rand_vec(), rand_vec());
                end
                bus.in_valid = 1'b0;
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        idle(6);
        check("stream_drained", BW'(exp_q.size()), '0);

        // Full-throughput stretch: 20 back-to-back beats in 20 consecutive cycles.
        s0 = acc_log.size();
        for (int n = 0; n < 20; n++) send(2'($urandom_range(0, 3)), rand_vec(), rand_vec());
        bus.in_valid = 1'b0;
        s1 = acc_log.size();
        if (s1 - s0 == 20)
            check("throughput", BW'(acc_log[s1-1] - acc_log[s0]), BW'(19));
        else
            check("throughput_count", BW'(s1 - s0), BW'(20));
        idle(4);

        // Asynchronous reset while FULL.
        bus.out_ready = 1'b0;
        send(2'd1, {CH_NUM{24'h000100}}, {CH_NUM{24'h000001}});
        send(2'd1, {CH_NUM{24'h000200}}, {CH_NUM{24'h000002}});
        bus.in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_bit("arst_out_valid", bus.out_valid, 1'b0);
        check_bit("arst_in_ready", bus.in_ready, 1'b1);
        check("arst_out_data", bus.out_data, '0);
        check("arst_sat", BW'(bus.sat_flag), '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        ve = {CH_NUM{24'h0ABCDE}};
        send(2'd0, ve, vz);
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_bit("post_rst_valid", bus.out_valid, 1'b1);
        check("post_rst_data", bus.out_data, {CH_NUM{24'h0ABCDE}});
        idle(4);
        check("post_rst_drained", BW'(exp_q.size()), '0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
